// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: builds one record per retired instruction and queues it in a FIFO.
// Optional macro TRACE_TYPE_CHECK_EN enables strict one-hot checking of type_wb.
module retire_trace_buffer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned MAX_INSTR = 200
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         instr_retired,
   input  logic [31:0]  pc_wb,
   input  logic [31:0]  instr_wb,
   input  logic [4:0]   rd_wb,
   input  logic [31:0]  rd_val_wb,
   input  logic [5:0]   type_wb,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [103:0] out_rec,
   output logic [31:0]  retire_count,
   output logic [15:0]  drop_count,
   output logic         overflow,
   output logic         type_err,
   output logic         done
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [103:0] mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   occ_q, occ_d;
   logic [31:0]   retire_count_q;
   logic [15:0]   drop_count_q;
   logic          overflow_q, done_q;

   logic [2:0]    type_code;
   logic [4:0]    rec_rd;
   logic [31:0]   rec_val;
   logic [103:0]  rec;
   logic          accept, full, pop, push, drop, hit_limit;

`ifdef TRACE_TYPE_CHECK_EN
   logic type_bad;
   logic type_err_q;

   always_comb begin
      type_bad  = 1'b0;
      type_code = 3'd7;
      unique case (type_wb)
         6'b000001: type_code = 3'd0;
         6'b000010: type_code = 3'd1;
         6'b000100: type_code = 3'd2;
         6'b001000: type_code = 3'd3;
         6'b010000: type_code = 3'd4;
         6'b100000: type_code = 3'd5;
         default:   type_bad  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         type_err_q <= 1'b0;
      end else if (accept && type_bad) begin
         type_err_q <= 1'b1;
      end
   end

   assign type_err = type_err_q;
`else
   // Lowest set bit wins; all-zero stays invalid.
   always_comb begin
      type_code = 3'd7;
      for (int i = 5; i >= 0; i--) begin
         if (type_wb[i]) type_code = 3'(i);
      end
   end

   assign type_err = 1'b0;
`endif

   always_comb begin
      rec_rd  = rd_wb;
      rec_val = rd_val_wb;
      if (type_code == 3'd2 || type_code == 3'd3) begin
         rec_rd  = 5'd0;
         rec_val = 32'd0;
      end
      if (rd_wb == 5'd0) rec_val = 32'd0;
   end

   assign rec = {type_code, rec_rd, pc_wb, instr_wb, rec_val};

   assign out_valid = (occ_q != '0);
   assign full      = (occ_q == (AW+1)'(DEPTH));
   assign pop       = out_valid && out_ready;
   assign accept    = instr_retired && !done_q;
   // A full FIFO still takes the record when the head leaves at the same edge.
   assign push      = accept && (!full || pop);
   assign drop      = accept && full && !pop;
   assign hit_limit = (MAX_INSTR != 0) && (retire_count_q + 32'd1 == 32'(MAX_INSTR));

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + {{AW{1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{AW{1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         occ_q          <= '0;
         retire_count_q <= '0;
         drop_count_q   <= '0;
         overflow_q     <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         occ_q <= occ_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (accept) begin
            retire_count_q <= retire_count_q + 32'd1;
            if (hit_limit) done_q <= 1'b1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rec;
   end

   assign out_rec      = mem_q[rd_ptr_q];
   assign retire_count = retire_count_q;
   assign drop_count   = drop_count_q;
   assign overflow     = overflow_q;
   assign done         = done_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_retire_trace_buffer;

   localparam int DEPTH     = 16;
   localparam int MAX_INSTR = 200;

   logic         clk = 1'b0;
   logic         reset;
   logic         instr_retired;
   logic [31:0]  pc_wb, instr_wb, rd_val_wb;
   logic [4:0]   rd_wb;
   logic [5:0]   type_wb;
   logic         out_valid, out_ready;
   logic [103:0] out_rec;
   logic [31:0]  retire_count;
   logic [15:0]  drop_count;
   logic         overflow, type_err, done;

   retire_trace_buffer #(.DEPTH(DEPTH), .MAX_INSTR(MAX_INSTR)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_retired(instr_retired),
      .pc_wb        (pc_wb),
      .instr_wb     (instr_wb),
      .rd_wb        (rd_wb),
      .rd_val_wb    (rd_val_wb),
      .type_wb      (type_wb),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rec      (out_rec),
      .retire_count (retire_count),
      .drop_count   (drop_count),
      .overflow     (overflow),
      .type_err     (type_err),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [103:0] mq[$];
   int m_cnt, m_drop;
   bit m_ovf, m_done, m_terr;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic bit type_invalid(logic [5:0] t);
`ifdef TRACE_TYPE_CHECK_EN
      return $countones(t) != 1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [103:0] exp_rec(logic [5:0] t, logic [4:0] rd, logic [31:0] pc,
                                            logic [31:0] ins, logic [31:0] val);
      int code = 7;
      for (int i = 5; i >= 0; i--) if (t[i]) code = i;
      if (type_invalid(t)) code = 7;
      if (code == 2 || code == 3) begin
         rd  = 5'd0;
         val = 32'd0;
      end
      if (rd == 5'd0) val = 32'd0;
      return {3'(code), rd, pc, ins, val};
   endfunction

   task automatic compare_all();
      check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) check("out_rec", 128'(out_rec), 128'(mq[0]));
      check("retire_count", 128'(retire_count), 128'(m_cnt));
      check("drop_count", 128'(drop_count), 128'(m_drop));
      check("overflow", 128'(overflow), 128'(m_ovf));
      check("done", 128'(done), 128'(m_done));
      check("type_err", 128'(type_err), 128'(m_terr));
   endtask

   task automatic model_clear();
      mq.delete();
      m_cnt  = 0;
      m_drop = 0;
      m_ovf  = 0;
      m_done = 0;
      m_terr = 0;
   endtask

   task automatic step(bit ret, bit rdy, logic [5:0] t, logic [4:0] rd, logic [31:0] pc,
                       logic [31:0] ins, logic [31:0] val);
      bit pop;
      instr_retired = ret;
      out_ready     = rdy;
      type_wb       = t;
      rd_wb         = rd;
      pc_wb         = pc;
      instr_wb      = ins;
      rd_val_wb     = val;
      @(posedge clk);
      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (ret && !m_done) begin
         m_cnt++;
         if (mq.size() < DEPTH) mq.push_back(exp_rec(t, rd, pc, ins, val));
         else begin
            if (m_drop < 16'hFFFF) m_drop++;
            m_ovf = 1;
         end
         if (type_invalid(t)) m_terr = 1;
         if (m_cnt == MAX_INSTR) m_done = 1;
      end
      #1;
      compare_all();
   endtask

   task automatic rstep(bit ret, bit rdy);
      logic [5:0] t;
      if ($urandom_range(0, 3) != 0) t = 6'(1 << $urandom_range(0, 5));
      else t = 6'($urandom);
      step(ret, rdy, t, 5'($urandom), $urandom, $urandom, $urandom);
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      instr_retired = 1'b0;
      out_ready     = 1'b0;
      repeat (5) @(posedge clk);
      model_clear();
      #1;
      compare_all();
      reset = 1'b1;
   endtask

   typedef struct {
      logic [5:0]  t;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [2:0]  e_code;
      logic [4:0]  e_rd;
      logic [31:0] e_val;
   } vec_t;

   vec_t vecs[8];
   int cnt;

   initial begin
      vecs[0] = '{6'h02, 5'd1, 32'd5, 3'd1, 5'd1, 32'd5};
      vecs[1] = '{6'h04, 5'd7, 32'h55, 3'd2, 5'd0, 32'd0};
      vecs[2] = '{6'h01, 5'd0, 32'h1234, 3'd0, 5'd0, 32'd0};
      vecs[3] = '{6'h08, 5'd3, 32'd9, 3'd3, 5'd0, 32'd0};
      vecs[4] = '{6'h10, 5'd4, 32'hAB, 3'd4, 5'd4, 32'hAB};
      vecs[5] = '{6'h20, 5'd31, 32'hFFFF_FFFF, 3'd5, 5'd31, 32'hFFFF_FFFF};
      vecs[6] = '{6'h00, 5'd2, 32'd7, 3'd7, 5'd2, 32'd7};
`ifdef TRACE_TYPE_CHECK_EN
      vecs[7] = '{6'h03, 5'd6, 32'd8, 3'd7, 5'd6, 32'd8};
`else
      vecs[7] = '{6'h03, 5'd6, 32'd8, 3'd0, 5'd6, 32'd8};
`endif

      // Vector table, including the basic record
      do_reset();
      for (int i = 0; i < 8; i++) begin
         logic [31:0] pc;
         pc = (i == 0) ? 32'h2000 : 32'h3000 + 32'(i * 4);
         step(1, 0, vecs[i].t, vecs[i].rd, pc, 32'h0050_0093, vecs[i].val);
         check("vec_code", 128'(out_rec[103:101]), 128'(vecs[i].e_code));
         check("vec_rd", 128'(out_rec[100:96]), 128'(vecs[i].e_rd));
         check("vec_val", 128'(out_rec[31:0]), 128'(vecs[i].e_val));
         if (i == 0) begin
            check("basic_rec", 128'(out_rec), 128'({3'd1, 5'd1, 32'h2000, 32'h0050_0093, 32'd5}));
            check("basic_count", 128'(retire_count), 128'd1);
         end
         if (i == 7) begin
`ifdef TRACE_TYPE_CHECK_EN
            check("type_err_set", 128'(type_err), 128'd1);
`else
            check("type_err_tied", 128'(type_err), 128'd0);
`endif
         end
         step(0, 1, 6'h0, 5'd0, 32'd0, 32'd0, 32'd0);
      end

      // Overflow: 20 retires into a 16-deep FIFO
      do_reset();
      for (int i = 0; i < 20; i++) rstep(1, 0);
      check("ovf_drop", 128'(drop_count), 128'd4);
      check("ovf_flag", 128'(overflow), 128'd1);
      check("ovf_count", 128'(retire_count), 128'd20);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) cnt++;
         rstep(0, 1);
      end
      check("ovf_pops", 128'(cnt), 128'd16);

      // Full with simultaneous pop, then streaming through pointer wrap
      do_reset();
      for (int i = 0; i < DEPTH; i++) rstep(1, 0);
      rstep(1, 1);
      check("full_pop_drop", 128'(drop_count), 128'd0);
      for (int i = 0; i < 40; i++) rstep(1, 1);
      check("stream_drop", 128'(drop_count), 128'd0);
      check("stream_ovf", 128'(overflow), 128'd0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) cnt++;
         rstep(0, 1);
      end
      check("full_occupancy", 128'(cnt), 128'(DEPTH));

      // Done at MAX_INSTR
      do_reset();
      cnt = 0;
      for (int i = 0; i < MAX_INSTR + 5; i++) begin
         if (out_valid) cnt++;
         rstep(1, 1);
      end
      for (int i = 0; i < 5; i++) begin
         if (out_valid) cnt++;
         rstep(0, 1);
      end
      check("done_flag", 128'(done), 128'd1);
      check("done_count", 128'(retire_count), 128'(MAX_INSTR));
      check("done_pops", 128'(cnt), 128'(MAX_INSTR));

      // Asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 8; i++) rstep(1, 0);
      instr_retired = 1'b0;
      out_ready     = 1'b0;
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("arst_valid", 128'(out_valid), 128'd0);
      check("arst_count", 128'(retire_count), 128'd0);
      check("arst_drop", 128'(drop_count), 128'd0);
      check("arst_flags", 128'({overflow, type_err, done}), 128'd0);
      model_clear();
      @(posedge clk);
      #1 reset = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) rstep($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
